// File: rtl/regfile_port_arbiter.sv
// Write-port arbiter for the 32x32 register file, shared by writeback, MDU and CP0,
// plus a pending-MDU-write scoreboard used by decode for RAW hazard stalls.
module regfile_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_req,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  input  logic        mdu_req,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  input  logic        cp0_req,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_data,
  output logic        pipe_gnt,
  output logic        mdu_gnt,
  output logic        cp0_gnt,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic        mdu_issue,
  input  logic [4:0]  mdu_issue_addr,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic        rs_busy,
  output logic        rt_busy,
  output logic        sb_conflict
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [2:0]  mdu_wait_q, mdu_wait_d;
  logic [2:0]  cp0_wait_q, cp0_wait_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        wr_mdu_q, wr_mdu_d;
  logic [31:1] busy_q, busy_d;
  logic        sb_conflict_q, sb_conflict_d;
  logic [31:0] busy_vec;
  logic        mdu_boost, cp0_boost;

  assign mdu_boost = mdu_req && (mdu_wait_q >= LIMIT);
  assign cp0_boost = cp0_req && (cp0_wait_q >= LIMIT);

  always_comb begin
    pipe_gnt = 1'b0;
    mdu_gnt  = 1'b0;
    cp0_gnt  = 1'b0;
    if (rst) begin
      if (mdu_boost)      mdu_gnt  = 1'b1;
      else if (cp0_boost) cp0_gnt  = 1'b1;
      else if (pipe_req)  pipe_gnt = 1'b1;
      else if (mdu_req)   mdu_gnt  = 1'b1;
      else if (cp0_req)   cp0_gnt  = 1'b1;
    end
  end

  // Counters only run while a request is actually being refused.
  always_comb begin
    mdu_wait_d = 3'd0;
    cp0_wait_d = 3'd0;
    if (mdu_req && !mdu_gnt) mdu_wait_d = (mdu_wait_q == 3'd7) ? 3'd7 : mdu_wait_q + 3'd1;
    if (cp0_req && !cp0_gnt) cp0_wait_d = (cp0_wait_q == 3'd7) ? 3'd7 : cp0_wait_q + 3'd1;
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    wr_mdu_d   = 1'b0;
    if (pipe_gnt) begin
      rf_waddr_d = pipe_addr;
      rf_wdata_d = pipe_data;
    end else if (mdu_gnt) begin
      rf_waddr_d = mdu_addr;
      rf_wdata_d = mdu_data;
      wr_mdu_d   = 1'b1;
    end else if (cp0_gnt) begin
      rf_waddr_d = cp0_addr;
      rf_wdata_d = cp0_data;
    end
    if (pipe_gnt || mdu_gnt || cp0_gnt) rf_we_d = (rf_waddr_d != 5'd0);
  end

  // Clear uses the write stage, so the falling-edge write has landed before busy drops.
  for (genvar gi = 1; gi < 32; gi++) begin : g_busy
    logic set_bit, clr_bit;
    assign set_bit    = mdu_issue && (mdu_issue_addr == 5'(gi));
    assign clr_bit    = wr_mdu_q && (rf_waddr_q == 5'(gi));
    assign busy_d[gi] = set_bit || (busy_q[gi] && !clr_bit);
  end

  assign busy_vec      = {busy_q, 1'b0};
  assign sb_conflict_d = mdu_issue && (mdu_issue_addr != 5'd0) && busy_vec[mdu_issue_addr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      mdu_wait_q    <= 3'd0;
      cp0_wait_q    <= 3'd0;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= 5'd0;
      rf_wdata_q    <= 32'd0;
      wr_mdu_q      <= 1'b0;
      busy_q        <= '0;
      sb_conflict_q <= 1'b0;
    end else begin
      mdu_wait_q    <= mdu_wait_d;
      cp0_wait_q    <= cp0_wait_d;
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      wr_mdu_q      <= wr_mdu_d;
      busy_q        <= busy_d;
      sb_conflict_q <= sb_conflict_d;
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign sb_conflict = sb_conflict_q;
  assign rs_busy     = busy_vec[rs_addr];
  assign rt_busy     = busy_vec[rt_addr];

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter: expected register-file writes are queued
// at grant time and a separate monitor checks every rf_we pulse against the queue.
module tb_regfile_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pipe_req = 1'b0, mdu_req = 1'b0, cp0_req = 1'b0;
  logic [4:0]  pipe_addr = '0, mdu_addr = '0, cp0_addr = '0;
  logic [31:0] pipe_data = '0, mdu_data = '0, cp0_data = '0;
  logic        pipe_gnt, mdu_gnt, cp0_gnt;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mdu_issue = 1'b0;
  logic [4:0]  mdu_issue_addr = '0;
  logic [4:0]  rs_addr = '0, rt_addr = '0;
  logic        rs_busy, rt_busy, sb_conflict;

  int total = 0;
  int bad = 0;
  logic [36:0] exp_q[$];

  regfile_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_req(pipe_req), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .mdu_req(mdu_req), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .cp0_req(cp0_req), .cp0_addr(cp0_addr), .cp0_data(cp0_data),
    .pipe_gnt(pipe_gnt), .mdu_gnt(mdu_gnt), .cp0_gnt(cp0_gnt),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mdu_issue(mdu_issue), .mdu_issue_addr(mdu_issue_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .sb_conflict(sb_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end else begin
      $display("ok   %s = 0x%08h at %0t", name, act, $time);
    end
  endtask

  task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grants(input string name, input logic [2:0] req);
    #1;
    check(name, {29'd0, pipe_gnt, mdu_gnt, cp0_gnt}, {29'd0, req});
  endtask

  // Monitor: every register-file write must match the oldest queued expectation.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (rf_we === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL write: unexpected rf_we addr=%0d data=0x%08h at %0t", rf_waddr, rf_wdata, $time);
        end else begin
          e = exp_q.pop_front();
          if (rf_waddr !== e[36:32] || rf_wdata !== e[31:0]) begin
            bad++;
            $display("FAIL write: got addr=%0d data=0x%08h expected addr=%0d data=0x%08h at %0t",
                     rf_waddr, rf_wdata, e[36:32], e[31:0], $time);
          end else begin
            $display("ok   write addr=%0d data=0x%08h at %0t", rf_waddr, rf_wdata, $time);
          end
        end
      end
    end
  end

  initial begin
    // Reset with all three requesting.
    pipe_req = 1; pipe_addr = 5'd5; pipe_data = 32'h11;
    mdu_req  = 1; mdu_addr  = 5'd6; mdu_data  = 32'h22;
    cp0_req  = 1; cp0_addr  = 5'd7; cp0_data  = 32'h33;
    rs_addr  = 5'd5;
    tick(); tick();
    grants("reset_gnt", 3'b000);
    check("reset_we", {31'd0, rf_we}, 32'd0);
    check("reset_waddr", {27'd0, rf_waddr}, 32'd0);
    check("reset_wdata", rf_wdata, 32'd0);
    check("reset_rs_busy", {31'd0, rs_busy}, 32'd0);

    // Priority: pipe, mdu, cp0 in consecutive cycles.
    rst = 1;
    grants("prio_c0", 3'b100); expect_write(5'd5, 32'h11);
    tick(); pipe_req = 0;
    grants("prio_c1", 3'b010); expect_write(5'd6, 32'h22);
    tick(); mdu_req = 0;
    grants("prio_c2", 3'b001); expect_write(5'd7, 32'h33);
    tick(); cp0_req = 0;
    grants("prio_c3", 3'b000);
    tick(); tick();

    // Starvation: mdu boosted in cycle 4 of continuous pipe traffic.
    mdu_req = 1; mdu_addr = 5'd11; mdu_data = 32'h44;
    for (int i = 0; i < 4; i++) begin
      pipe_req = 1; pipe_addr = 5'd10; pipe_data = 32'h100 + 32'(i);
      grants("starve_pipe", 3'b100); expect_write(5'd10, 32'h100 + 32'(i));
      tick();
    end
    pipe_data = 32'h104;
    grants("starve_mdu_c4", 3'b010); expect_write(5'd11, 32'h44);
    tick(); mdu_req = 0;
    grants("starve_pipe_c5", 3'b100); expect_write(5'd10, 32'h104);
    tick(); pipe_req = 0;
    tick();

    // $0 write is granted but never enables the register file.
    pipe_req = 1; pipe_addr = 5'd0; pipe_data = 32'hDEADBEEF; rs_addr = 5'd0;
    grants("zero_gnt", 3'b100);
    tick(); pipe_req = 0;
    #1;
    check("zero_we", {31'd0, rf_we}, 32'd0);
    check("zero_wdata", rf_wdata, 32'hDEADBEEF);
    check("zero_rs_busy", {31'd0, rs_busy}, 32'd0);
    tick();

    // Scoreboard set at cycle 0, MDU writeback in cycle 10.
    rs_addr = 5'd9; rt_addr = 5'd0;
    mdu_issue = 1; mdu_issue_addr = 5'd9;
    #1; check("sb_c0_rs_busy", {31'd0, rs_busy}, 32'd0);
    tick(); mdu_issue = 0;
    #1; check("sb_c1_rs_busy", {31'd0, rs_busy}, 32'd1);
    check("sb_c1_rt_busy0", {31'd0, rt_busy}, 32'd0);
    for (int c = 2; c <= 10; c++) tick();
    mdu_req = 1; mdu_addr = 5'd9; mdu_data = 32'h99;
    grants("sb_c10_gnt", 3'b010); expect_write(5'd9, 32'h99);
    tick(); mdu_req = 0;
    #1; check("sb_c11_rs_busy", {31'd0, rs_busy}, 32'd1);
    tick();
    #1; check("sb_c12_rs_busy", {31'd0, rs_busy}, 32'd0);

    // Double issue to $3 raises a one-cycle conflict.
    rt_addr = 5'd3;
    mdu_issue = 1; mdu_issue_addr = 5'd3;
    tick();
    #1; check("cf_c1_conflict", {31'd0, sb_conflict}, 32'd0);
    tick(); mdu_issue = 0;
    #1; check("cf_c2_conflict", {31'd0, sb_conflict}, 32'd1);
    check("cf_c2_rt_busy", {31'd0, rt_busy}, 32'd1);
    tick();
    #1; check("cf_c3_conflict", {31'd0, sb_conflict}, 32'd0);
    check("cf_c3_rt_busy", {31'd0, rt_busy}, 32'd1);

    // Mid-run reset drops a pending request and clears the scoreboard.
    pipe_req = 1; pipe_addr = 5'd12; pipe_data = 32'h55;
    rst = 0;
    grants("mid_reset_gnt", 3'b000);
    tick(); pipe_req = 0;
    #1; check("mid_reset_rt_busy", {31'd0, rt_busy}, 32'd0);
    check("mid_reset_we", {31'd0, rf_we}, 32'd0);
    rst = 1;
    tick(); tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
